// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: FSM state type, round count, inverse S-box
// and GF(2^8) helpers used by the inverse cipher datapath.
package aes_pkg;

   localparam int NR    = 10;
   localparam int BLK_W = 128;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} dec_state_t;

   // Element 0 sits in the most significant byte, so row-by-row hex reads naturally.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX[x];
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = gf_mul2(p);
      end
      return acc;
   endfunction

   function automatic logic [BLK_W-1:0] add_roundkey(input logic [BLK_W-1:0] st,
                                                     input logic [BLK_W-1:0] rk);
      return st ^ rk;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [BLK_W-1:0] st,
   input  logic [BLK_W-1:0] rk,
   input  logic             last,
   output logic [BLK_W-1:0] result
);

   logic [BLK_W-1:0] sub_st;
   logic [BLK_W-1:0] key_st;
   logic [BLK_W-1:0] mix_st;

   // Byte i = row + 4*col; row r is rotated right by r columns.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_byte
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
         assign sub_st[127-8*gi -: 8] = inv_sbox(st[127-8*SRC -: 8]);
      end
   endgenerate

   assign key_st = add_roundkey(sub_st, rk);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_col
         logic [7:0] a0, a1, a2, a3;
         assign a0 = key_st[127-32*gi -: 8];
         assign a1 = key_st[119-32*gi -: 8];
         assign a2 = key_st[111-32*gi -: 8];
         assign a3 = key_st[103-32*gi -: 8];
         assign mix_st[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         assign mix_st[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         assign mix_st[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         assign mix_st[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
   endgenerate

   assign result = last ? key_st : mix_st;

endmodule

// File: rtl/top_decryption.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys indexed
// from the key-expansion decryption port.
module top_decryption
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             restart,
   input  logic [BLK_W-1:0] cipher_text,
   output logic             req_key,
   output logic [3:0]       key_idx,
   input  logic [BLK_W-1:0] round_key,
   output logic             busy,
   output logic             done,
   output logic [BLK_W-1:0] plain_text
);

   dec_state_t       state_reg, state_next;
   logic [3:0]       rnd_reg, rnd_next;
   logic [BLK_W-1:0] st_reg, st_next;
   logic [BLK_W-1:0] pt_reg, pt_next;
   logic             done_reg, done_next;
   logic [BLK_W-1:0] round_out;

   aes_inv_round u_round (
      .st     (st_reg),
      .rk     (round_key),
      .last   (state_reg == FINAL),
      .result (round_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         rnd_reg   <= 4'd0;
         st_reg    <= '0;
         pt_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         rnd_reg   <= rnd_next;
         st_reg    <= st_next;
         pt_reg    <= pt_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      rnd_next   = rnd_reg;
      st_next    = st_reg;
      pt_next    = pt_reg;
      done_next  = 1'b0;
      req_key    = 1'b0;
      key_idx    = 4'd0;
      case (state_reg)
         IDLE: begin
            key_idx = 4'(NR);
            req_key = start;
            if (start) begin
               st_next    = add_roundkey(cipher_text, round_key);
               rnd_next   = 4'(NR - 1);
               state_next = ROUND;
            end
         end
         ROUND: begin
            key_idx  = rnd_reg;
            req_key  = 1'b1;
            st_next  = round_out;
            rnd_next = rnd_reg - 4'd1;
            if (rnd_reg == 4'd1) state_next = FINAL;
         end
         FINAL: begin
            key_idx    = 4'd0;
            req_key    = 1'b1;
            pt_next    = round_out;
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Abort discards the block in flight and keeps the last published result.
      if (restart) begin
         state_next = IDLE;
         rnd_next   = 4'd0;
         st_next    = st_reg;
         pt_next    = pt_reg;
         done_next  = 1'b0;
      end
      if (!reset_n) begin
         req_key = 1'b0;
         key_idx = 4'd0;
      end
   end

   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign plain_text = pt_reg;

endmodule

// File: tb/tb_top_decryption.sv
// Directed bench for top_decryption: FIPS-197 vectors, key index trace,
// back-to-back, busy-start, restart and asynchronous reset scenarios.
module tb_top_decryption;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         restart = 1'b0;
   logic [127:0] cipher_text = '0;
   logic [127:0] round_key;
   logic         req_key;
   logic [3:0]   key_idx;
   logic         busy;
   logic         done;
   logic [127:0] plain_text;

   logic [127:0] rk_tab [0:10];
   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

   always #5 clk = ~clk;

   assign round_key = (key_idx <= 4'd10) ? rk_tab[key_idx] : '0;

   top_decryption dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .restart     (restart),
      .cipher_text (cipher_text),
      .req_key     (req_key),
      .key_idx     (key_idx),
      .round_key   (round_key),
      .busy        (busy),
      .done        (done),
      .plain_text  (plain_text)
   );

   function automatic logic [7:0] m_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = m_xtime(p);
      end
      return acc;
   endfunction

   // Forward S-box from its definition: x^254 then the affine map.
   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = m_mul(inv, x);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])} ^ {rc, 24'h0};
            rc = m_xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({busy, done, req_key, key_idx} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want %b", {busy, done, req_key, key_idx}, 7'b0);
      end
      n_cmp++;
      if (plain_text !== 128'h0) begin
         n_bad++;
         $display("FAIL reset_pt: got %h want 0", plain_text);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({busy, done, req_key, key_idx} !== {3'b000, 4'd10}) begin
         n_bad++;
         $display("FAIL idle_outputs: got %b want %b", {busy, done, req_key, key_idx}, {3'b000, 4'd10});
      end
      $display("test_reset done");
   endtask

   task automatic test_fips_c1();
      load_key(KEY_C1);
      @(negedge clk);
      start = 1'b1;
      cipher_text = CT_C1;
      #1;
      n_cmp++;
      if ({req_key, key_idx, busy} !== {1'b1, 4'd10, 1'b0}) begin
         n_bad++;
         $display("FAIL key_trace_10: got %b want %b", {req_key, key_idx, busy}, {1'b1, 4'd10, 1'b0});
      end
      for (int k = 9; k >= 0; k--) begin
         @(negedge clk);
         start = 1'b0;
         cipher_text = ~CT_C1 ^ 128'(k);
         #1;
         n_cmp++;
         if ({req_key, key_idx, busy, done} !== {1'b1, 4'(k), 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL key_trace_%0d: got %b want %b", k, {req_key, key_idx, busy, done},
                     {1'b1, 4'(k), 1'b1, 1'b0});
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({done, busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL c1_done_at_11: got done,busy=%b want 10", {done, busy});
      end
      n_cmp++;
      if (plain_text !== PT_C1) begin
         n_bad++;
         $display("FAIL c1_plaintext: got %h want %h", plain_text, PT_C1);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0 || plain_text !== PT_C1) begin
         n_bad++;
         $display("FAIL c1_pulse_hold: got done=%b pt=%h want done=0 pt=%h", done, plain_text, PT_C1);
      end
      $display("test_fips_c1 pt=%h", plain_text);
   endtask

   task automatic test_fips_b();
      int cyc;
      logic got;
      load_key(KEY_B);
      @(negedge clk);
      start = 1'b1;
      cipher_text = CT_B;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 30) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         #1;
         if (done) got = 1'b1;
      end
      n_cmp++;
      if (!got || cyc != 11) begin
         n_bad++;
         $display("FAIL b_latency: got seen=%b cycles=%0d want seen=1 cycles=11", got, cyc);
      end
      n_cmp++;
      if (plain_text !== PT_B) begin
         n_bad++;
         $display("FAIL b_plaintext: got %h want %h", plain_text, PT_B);
      end
      $display("test_fips_b cycles=%0d pt=%h", cyc, plain_text);
   endtask

   task automatic test_back_to_back();
      load_key(KEY_C1);
      @(negedge clk);
      start = 1'b1;
      cipher_text = CT_C1;
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b1 || plain_text !== PT_C1) begin
         n_bad++;
         $display("FAIL b2b_first: got done=%b pt=%h want done=1 pt=%h", done, plain_text, PT_C1);
      end
      load_key(KEY_B);
      start = 1'b1;
      cipher_text = CT_B;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         n_cmp++;
         if (done !== 1'b0 || plain_text !== PT_C1) begin
            n_bad++;
            $display("FAIL b2b_hold_%0d: got done=%b pt=%h want done=0 pt=%h", c, done, plain_text, PT_C1);
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b1 || plain_text !== PT_B) begin
         n_bad++;
         $display("FAIL b2b_second: got done=%b pt=%h want done=1 pt=%h", done, plain_text, PT_B);
      end
      $display("test_back_to_back pt=%h", plain_text);
   endtask

   task automatic test_start_while_busy();
      int n_done;
      int done_cyc;
      load_key(KEY_B);
      @(negedge clk);
      start = 1'b1;
      cipher_text = CT_B;
      n_done = 0;
      done_cyc = 0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         start = (c == 5);
         cipher_text = (c == 5) ? CT_C1 : 128'h0;
         #1;
         if (done) begin
            n_done++;
            done_cyc = c;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (n_done != 1 || done_cyc != 11) begin
         n_bad++;
         $display("FAIL busy_start_dones: got count=%0d at=%0d want count=1 at=11", n_done, done_cyc);
      end
      n_cmp++;
      if (plain_text !== PT_B) begin
         n_bad++;
         $display("FAIL busy_start_pt: got %h want %h", plain_text, PT_B);
      end
      $display("test_start_while_busy dones=%0d", n_done);
   endtask

   task automatic test_restart();
      int n_done;
      int cyc;
      logic got;
      load_key(KEY_C1);
      @(negedge clk);
      start = 1'b1;
      cipher_text = CT_C1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         restart = (c == 4);
      end
      @(negedge clk);
      restart = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL restart_idle: got busy,done=%b want 00", {busy, done});
      end
      n_done = 0;
      repeat (15) begin
         @(negedge clk);
         #1;
         if (done) n_done++;
      end
      n_cmp++;
      if (n_done != 0 || plain_text !== PT_B) begin
         n_bad++;
         $display("FAIL restart_no_done: got dones=%0d pt=%h want dones=0 pt=%h", n_done, plain_text, PT_B);
      end
      @(negedge clk);
      start = 1'b1;
      restart = 1'b1;
      @(negedge clk);
      start = 1'b0;
      restart = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_wins: got busy=%b want 0", busy);
      end
      @(negedge clk);
      start = 1'b1;
      cipher_text = CT_C1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 30) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         #1;
         if (done) got = 1'b1;
      end
      n_cmp++;
      if (!got || cyc != 11 || plain_text !== PT_C1) begin
         n_bad++;
         $display("FAIL restart_then_start: got seen=%b cycles=%0d pt=%h want seen=1 cycles=11 pt=%h",
                  got, cyc, plain_text, PT_C1);
      end
      $display("test_restart cycles=%0d pt=%h", cyc, plain_text);
   endtask

   task automatic test_reset_mid_block();
      int n_done;
      load_key(KEY_B);
      @(negedge clk);
      start = 1'b1;
      cipher_text = CT_B;
      repeat (3) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, req_key, key_idx} !== 7'b0 || plain_text !== 128'h0) begin
         n_bad++;
         $display("FAIL async_reset: got ctrl=%b pt=%h want ctrl=0 pt=0", {busy, done, req_key, key_idx}, plain_text);
      end
      @(negedge clk);
      reset_n = 1'b1;
      n_done = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         if (done) n_done++;
      end
      n_cmp++;
      if (n_done != 0 || plain_text !== 128'h0) begin
         n_bad++;
         $display("FAIL reset_no_done: got dones=%0d pt=%h want dones=0 pt=0", n_done, plain_text);
      end
      $display("test_reset_mid_block dones=%0d", n_done);
   endtask

   initial begin
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_back_to_back();
      test_start_while_busy();
      test_restart();
      test_reset_mid_block();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
